// File: rtl/pf_stream_prefetcher.sv
// ---------------------------------------------------------------------------
// pf_stream_prefetcher
//
// A next-N-line stream prefetcher. It sits between the cache miss path and
// the prefetch port of the memory arbiter. A demand-miss trigger launches up
// to DEPTH sequential line reads, issued one at a time. The reads never leave
// the 2^PAGE_BITS-byte region of the trigger address. Returned lines go into
// a DEPTH-entry FIFO. The cache takes them over a valid/ack handshake.
//
// Parameters
//   DEPTH      lines fetched ahead per trigger, and FIFO entries (1..8)
//   WAY_W      width of the cache way tag carried with each line
//   PAGE_BITS  prefetch stays inside the 2^PAGE_BITS-byte region of the trigger
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   prefetch_start      one-cycle trigger on a demand miss
//   cacheline_address   miss address (bits [4:0] ignored)
//   cache_way           way that the prefetched lines will fill
//   pf_valid            FIFO head valid
//   prefetch_rdata      FIFO head data
//   pf_cline_address    FIFO head line address
//   pf_cache_way        FIFO head way
//   pf_ack              cache consumes the head while pf_valid
//   pf_read, pf_address memory read request and line address
//   pf_rdata, pf_resp   memory read data, and its completion strobe
//   pf_busy             state != IDLE or lines still remain to fetch
//
// Optional build macro
//   PF_STRIDE_EN  Adds stride detection. When two consecutive triggers show
//                 the same nonzero line stride, that stride becomes the
//                 prefetch step. Otherwise the step is +1 line.
// ---------------------------------------------------------------------------
module pf_stream_prefetcher #(
  parameter int DEPTH     = 2,
  parameter int WAY_W     = 1,
  parameter int PAGE_BITS = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             prefetch_start,
  input  logic [31:0]      cacheline_address,
  input  logic [WAY_W-1:0] cache_way,
  output logic             pf_valid,
  output logic [255:0]     prefetch_rdata,
  output logic [31:0]      pf_cline_address,
  output logic [WAY_W-1:0] pf_cache_way,
  input  logic             pf_ack,
  output logic             pf_read,
  output logic [31:0]      pf_address,
  input  logic [255:0]     pf_rdata,
  input  logic             pf_resp,
  output logic             pf_busy
);

  // state  | meaning
  // IDLE   | no read outstanding; launch the next one when lines remain and FIFO has room
  // REQ    | read for pf_address outstanding; data will be kept
  // ABORT  | stale read outstanding after a retrigger; data will be dropped

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [31:0]      LINE_STEP = 32'd32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ABORT = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [31:0]          next_addr_q, next_addr_d;
  logic [CNT_W-1:0]     remaining_q, remaining_d;
  logic [WAY_W-1:0]     way_q, way_d;
  logic [31:PAGE_BITS]  trig_page_q, trig_page_d;
  logic [31:0]          req_addr_q, req_addr_d;

  logic [255:0]         fifo_data_q [DEPTH];
  logic [31:0]          fifo_addr_q [DEPTH];
  logic [WAY_W-1:0]     fifo_way_q  [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;

  logic                 head_valid_q, head_valid_d;
  logic [255:0]         head_data_q, head_data_d;
  logic [31:0]          head_addr_q, head_addr_d;
  logic [WAY_W-1:0]     head_way_q, head_way_d;

  logic                 push;
  logic                 pop;
  logic                 flush;
  logic [26:0]          cur_line;
  logic [31:0]          trig_step;
  logic [31:0]          cur_step;
  logic [31:0]          trig_next;
  logic                 trig_in_page;
  logic [31:0]          adv_next;
  logic                 adv_in_page;
  logic                 unused_addr_bits;

  assign cur_line         = cacheline_address[31:5];
  assign unused_addr_bits = ^cacheline_address[4:0];

  // -------------------------------------------------------------------------
  // Prefetch step
  // -------------------------------------------------------------------------
`ifdef PF_STRIDE_EN
  logic [26:0]        prev_line_q, prev_line_d;
  logic signed [7:0]  prev_stride_q, prev_stride_d;
  logic [31:0]        step_q, step_d;
  logic signed [27:0] line_diff;
  logic signed [7:0]  new_stride;

  always_comb begin
    line_diff = $signed({1'b0, cur_line}) - $signed({1'b0, prev_line_q});
    if (line_diff > 28'sd127) begin
      new_stride = 8'sd127;
    end else if (line_diff < -28'sd128) begin
      new_stride = -8'sd128;
    end else begin
      new_stride = line_diff[7:0];
    end

    if ((new_stride == prev_stride_q) && (new_stride != 8'sd0)) begin
      trig_step = {{19{new_stride[7]}}, new_stride, 5'b0};
    end else begin
      trig_step = LINE_STEP;
    end

    prev_line_d   = prev_line_q;
    prev_stride_d = prev_stride_q;
    step_d        = step_q;
    if (prefetch_start) begin
      prev_line_d   = cur_line;
      prev_stride_d = new_stride;
      step_d        = trig_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_line_q   <= '0;
      prev_stride_q <= '0;
      step_q        <= LINE_STEP;
    end else begin
      prev_line_q   <= prev_line_d;
      prev_stride_q <= prev_stride_d;
      step_q        <= step_d;
    end
  end

  assign cur_step = step_q;
`else
  assign trig_step = LINE_STEP;
  assign cur_step  = LINE_STEP;
`endif

  // A carry or borrow out of bit 31 changes the page bits. So a 32-bit wrap
  // also counts as leaving the page.
  assign trig_next    = {cur_line, 5'b0} + trig_step;
  assign trig_in_page = (trig_next[31:PAGE_BITS] == cacheline_address[31:PAGE_BITS]);
  assign adv_next     = next_addr_q + cur_step;
  assign adv_in_page  = (adv_next[31:PAGE_BITS] == trig_page_q);

  // -------------------------------------------------------------------------
  // Request FSM and stream parameters
  // -------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    way_d       = way_q;
    trig_page_d = trig_page_q;
    req_addr_d  = req_addr_q;
    push        = 1'b0;
    flush       = 1'b0;

    // A trigger reloads the stream in every state. Any read still in flight
    // for the old stream is left to complete and its data is dropped.
    if (prefetch_start) begin
      next_addr_d = trig_next;
      remaining_d = trig_in_page ? DEPTH_C : '0;
      way_d       = cache_way;
      trig_page_d = cacheline_address[31:PAGE_BITS];
      flush       = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        // Holding IDLE in the trigger cycle gives the fixed T+2 read latency.
        if (!prefetch_start && (remaining_q != '0) && (count_q < DEPTH_C)) begin
          state_d    = ST_REQ;
          req_addr_d = next_addr_q;
        end
      end
      ST_REQ: begin
        if (prefetch_start) begin
          state_d = pf_resp ? ST_IDLE : ST_ABORT;
        end else if (pf_resp) begin
          push        = 1'b1;
          next_addr_d = adv_next;
          remaining_d = adv_in_page ? (remaining_q - 1'b1) : '0;
          state_d     = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (pf_resp) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Line FIFO with registered head
  // -------------------------------------------------------------------------
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == LAST_PTR) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  // A trigger takes priority over a pop in the same cycle.
  assign pop = pf_ack && head_valid_q && !prefetch_start;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    head_valid_d = head_valid_q;
    head_data_d  = head_data_q;
    head_addr_d  = head_addr_q;
    head_way_d   = head_way_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        count_d = count_q + 1'b1;
      end else if (pop && !push) begin
        count_d = count_q - 1'b1;
      end
    end

    head_valid_d = (count_d != '0);
    // The new head comes straight from the incoming line when that line is
    // going into the slot the head is about to point at. In every other case
    // it is already in storage.
    if (count_d != '0) begin
      if (push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))))) begin
        head_data_d = pf_rdata;
        head_addr_d = req_addr_q;
        head_way_d  = way_q;
      end else begin
        head_data_d = fifo_data_q[rd_ptr_d];
        head_addr_d = fifo_addr_q[rd_ptr_d];
        head_way_d  = fifo_way_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_data_q[wr_ptr_q] <= pf_rdata;
      fifo_addr_q[wr_ptr_q] <= req_addr_q;
      fifo_way_q[wr_ptr_q]  <= way_q;
    end
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      next_addr_q  <= '0;
      remaining_q  <= '0;
      way_q        <= '0;
      trig_page_q  <= '0;
      req_addr_q   <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      head_valid_q <= 1'b0;
      head_data_q  <= '0;
      head_addr_q  <= '0;
      head_way_q   <= '0;
    end else begin
      state_q      <= state_d;
      next_addr_q  <= next_addr_d;
      remaining_q  <= remaining_d;
      way_q        <= way_d;
      trig_page_q  <= trig_page_d;
      req_addr_q   <= req_addr_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_valid_q <= head_valid_d;
      head_data_q  <= head_data_d;
      head_addr_q  <= head_addr_d;
      head_way_q   <= head_way_d;
    end
  end

  assign pf_read          = (state_q != ST_IDLE);
  assign pf_address       = req_addr_q;
  assign pf_busy          = (state_q != ST_IDLE) || (remaining_q != '0);
  assign pf_valid         = head_valid_q;
  assign prefetch_rdata   = head_data_q;
  assign pf_cline_address = head_addr_q;
  assign pf_cache_way     = head_way_q;

endmodule

// File: tb/tb_pf_stream_prefetcher.sv
module tb_pf_stream_prefetcher;

  localparam int DEPTH = 2;
  localparam int WAY_W = 1;

  typedef struct packed {
    logic [31:0]      addr;
    logic [WAY_W-1:0] way;
    logic [255:0]     data;
  } sb_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             prefetch_start;
  logic [31:0]      cacheline_address;
  logic [WAY_W-1:0] cache_way;
  logic             pf_valid;
  logic [255:0]     prefetch_rdata;
  logic [31:0]      pf_cline_address;
  logic [WAY_W-1:0] pf_cache_way;
  logic             pf_ack;
  logic             pf_read;
  logic [31:0]      pf_address;
  logic [255:0]     pf_rdata;
  logic             pf_resp;
  logic             pf_busy;

  int  vectors     = 0;
  int  miscompares = 0;
  sb_t exp_q[$];

  always #5 clk = ~clk;

  pf_stream_prefetcher #(.DEPTH(DEPTH), .WAY_W(WAY_W), .PAGE_BITS(12)) dut (
    .clk               (clk),
    .rst               (rst),
    .prefetch_start    (prefetch_start),
    .cacheline_address (cacheline_address),
    .cache_way         (cache_way),
    .pf_valid          (pf_valid),
    .prefetch_rdata    (prefetch_rdata),
    .pf_cline_address  (pf_cline_address),
    .pf_cache_way      (pf_cache_way),
    .pf_ack            (pf_ack),
    .pf_read           (pf_read),
    .pf_address        (pf_address),
    .pf_rdata          (pf_rdata),
    .pf_resp           (pf_resp),
    .pf_busy           (pf_busy)
  );

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] mkdata(input logic [31:0] a);
    return {8{a ^ 32'hC0DE_0000}};
  endfunction

  task automatic do_reset();
    rst               = 1'b1;
    prefetch_start    = 1'b0;
    pf_ack            = 1'b0;
    pf_resp           = 1'b0;
    pf_rdata          = '0;
    cacheline_address = '0;
    cache_way         = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic trigger(input logic [31:0] addr, input logic [WAY_W-1:0] way);
    cacheline_address = addr;
    cache_way         = way;
    prefetch_start    = 1'b1;
    tick();
    prefetch_start    = 1'b0;
  endtask

  task automatic wait_read(input string tag);
    int n;
    n = 0;
    while (!pf_read && n < 30) begin
      tick();
      n++;
    end
    chk({tag, "_req_seen"}, pf_read, 1'b1);
  endtask

  task automatic serve(input string tag, input logic [31:0] addr, input logic [WAY_W-1:0] way,
                       input int delay, input bit keep);
    bit  stable;
    sb_t e;
    stable = 1'b1;
    wait_read(tag);
    chk({tag, "_addr"}, pf_address, addr);
    repeat (delay) begin
      tick();
      if (pf_read !== 1'b1 || pf_address !== addr) stable = 1'b0;
    end
    chk({tag, "_held"}, stable, 1'b1);
    pf_resp  = 1'b1;
    pf_rdata = mkdata(addr);
    if (keep) begin
      e.addr = addr;
      e.way  = way;
      e.data = mkdata(addr);
      exp_q.push_back(e);
    end
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    chk({tag, "_drop"}, pf_read, 1'b0);
  endtask

  task automatic pop_check(input string tag);
    sb_t e;
    chk({tag, "_valid"}, pf_valid, 1'b1);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL %s_sb: observed a pop, expected an empty scoreboard", tag);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_addr"}, pf_cline_address, e.addr);
      chk({tag, "_way"}, pf_cache_way, e.way);
      chk({tag, "_data"}, prefetch_rdata, e.data);
    end
    pf_ack = 1'b1;
    tick();
    pf_ack = 1'b0;
  endtask

  task automatic expect_idle(input string tag, input int n);
    bit saw;
    saw = 1'b0;
    repeat (n) begin
      if (pf_read) saw = 1'b1;
      tick();
    end
    chk(tag, saw, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    do_reset();
    chk("rst_valid", pf_valid, 1'b0);
    chk("rst_read", pf_read, 1'b0);
    chk("rst_busy", pf_busy, 1'b0);
    chk("rst_addr", pf_address, 32'h0);
    chk("rst_cline", pf_cline_address, 32'h0);
    chk("rst_way", pf_cache_way, 1'b0);
    chk("rst_data", prefetch_rdata, 256'h0);

    // Basic stream and trigger-to-read latency
    trigger(32'h1000_0040, 1'b1);
    chk("lat_t1_read", pf_read, 1'b0);
    chk("lat_t1_busy", pf_busy, 1'b1);
    tick();
    chk("lat_t2_read", pf_read, 1'b1);
    serve("basic0", 32'h1000_0060, 1'b1, 3, 1'b1);
    chk("basic_first_valid", pf_valid, 1'b1);
    serve("basic1", 32'h1000_0080, 1'b1, 3, 1'b1);
    chk("basic_busy_done", pf_busy, 1'b0);
    expect_idle("basic_no_third", 4);
    pop_check("basic_pop0");
    pop_check("basic_pop1");
    chk("basic_empty", pf_valid, 1'b0);

    // Backpressure: FIFO fills and no further reads
    do_reset();
    trigger(32'h3000_0000, 1'b0);
    serve("bp0", 32'h3000_0020, 1'b0, 1, 1'b1);
    serve("bp1", 32'h3000_0040, 1'b0, 1, 1'b1);
    expect_idle("bp_full_idle", 6);
    pop_check("bp_pop0");
    expect_idle("bp_after_ack_idle", 5);
    pop_check("bp_pop1");
    chk("bp_empty", pf_valid, 1'b0);

    // Page boundary, including 32-bit wrap
    do_reset();
    trigger(32'h0000_0FE0, 1'b0);
    chk("page_edge_busy", pf_busy, 1'b0);
    expect_idle("page_edge_noread", 6);
    trigger(32'hFFFF_FFE0, 1'b1);
    expect_idle("page_wrap_noread", 6);
    trigger(32'h0000_0FC0, 1'b1);
    serve("page_one", 32'h0000_0FE0, 1'b1, 2, 1'b1);
    expect_idle("page_one_only", 6);
    chk("page_busy_done", pf_busy, 1'b0);
    pop_check("page_pop");
    chk("page_empty", pf_valid, 1'b0);

    // Abort: retrigger while a read is pending
    do_reset();
    // 0x1FE0 leaves its page immediately. It also spaces the stride history,
    // so the triggers that follow never repeat a stride.
    trigger(32'h0000_1FE0, 1'b0);
    expect_idle("abort_prime_noread", 3);
    trigger(32'h0000_2000, 1'b0);
    wait_read("abort_old");
    chk("abort_old_addr", pf_address, 32'h0000_2020);
    tick();
    cacheline_address = 32'h0000_8000;
    cache_way         = 1'b1;
    prefetch_start    = 1'b1;
    tick();
    prefetch_start    = 1'b0;
    chk("abort_hold_read0", pf_read, 1'b1);
    chk("abort_hold_addr0", pf_address, 32'h0000_2020);
    tick();
    chk("abort_hold_read1", pf_read, 1'b1);
    chk("abort_hold_addr1", pf_address, 32'h0000_2020);
    pf_resp  = 1'b1;
    pf_rdata = mkdata(32'h0000_2020);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    chk("abort_drop_read", pf_read, 1'b0);
    chk("abort_discard", pf_valid, 1'b0);
    serve("abort_new0", 32'h0000_8020, 1'b1, 1, 1'b1);
    serve("abort_new1", 32'h0000_8040, 1'b1, 2, 1'b1);
    pop_check("abort_pop0");

    // A trigger in the same cycle as pf_ack flushes, and the pop is ignored
    cacheline_address = 32'h0000_8100;
    cache_way         = 1'b0;
    prefetch_start    = 1'b1;
    pf_ack            = 1'b1;
    tick();
    prefetch_start    = 1'b0;
    pf_ack            = 1'b0;
    chk("trig_ack_flush", pf_valid, 1'b0);
    exp_q.delete();
    serve("flush_new0", 32'h0000_8120, 1'b0, 1, 1'b1);
    serve("flush_new1", 32'h0000_8140, 1'b0, 1, 1'b1);
    pop_check("flush_pop0");
    pop_check("flush_pop1");

    // A trigger in the same cycle as pf_resp in REQ discards the data
    do_reset();
    trigger(32'h6000_0000, 1'b1);
    wait_read("tr_old");
    chk("tr_old_addr", pf_address, 32'h6000_0020);
    cacheline_address = 32'h5FFF_F000;
    cache_way         = 1'b0;
    prefetch_start    = 1'b1;
    pf_resp           = 1'b1;
    pf_rdata          = mkdata(32'h6000_0020);
    tick();
    prefetch_start    = 1'b0;
    pf_resp           = 1'b0;
    pf_rdata          = '0;
    chk("tr_read_drop", pf_read, 1'b0);
    chk("tr_discard", pf_valid, 1'b0);
    serve("tr_new0", 32'h5FFF_F020, 1'b0, 1, 1'b1);
    serve("tr_new1", 32'h5FFF_F040, 1'b0, 1, 1'b1);
    pop_check("tr_pop0");
    pop_check("tr_pop1");

    // Reset mid-REQ; a late response is ignored
    do_reset();
    trigger(32'h4000_0000, 1'b1);
    serve("rmid0", 32'h4000_0020, 1'b1, 1, 1'b0);
    wait_read("rmid1");
    chk("rmid1_addr", pf_address, 32'h4000_0040);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rmid_read", pf_read, 1'b0);
    chk("rmid_valid", pf_valid, 1'b0);
    chk("rmid_busy", pf_busy, 1'b0);
    chk("rmid_addr", pf_address, 32'h0);
    chk("rmid_cline", pf_cline_address, 32'h0);
    pf_resp  = 1'b1;
    pf_rdata = mkdata(32'h4000_0040);
    tick();
    pf_resp  = 1'b0;
    pf_rdata = '0;
    chk("rmid_late_valid", pf_valid, 1'b0);
    expect_idle("rmid_late_idle", 5);
    chk("rmid_late_busy", pf_busy, 1'b0);

    // Stride sequence: step only changes when the stride feature is built in
    do_reset();
    trigger(32'h0000_1000, 1'b0);
    trigger(32'h0000_1080, 1'b0);
    trigger(32'h0000_1100, 1'b1);
`ifdef PF_STRIDE_EN
    serve("stride0", 32'h0000_1180, 1'b1, 1, 1'b1);
    serve("stride1", 32'h0000_1200, 1'b1, 1, 1'b1);
`else
    serve("stride0", 32'h0000_1120, 1'b1, 1, 1'b1);
    serve("stride1", 32'h0000_1140, 1'b1, 1, 1'b1);
`endif
    pop_check("stride_pop0");
    pop_check("stride_pop1");
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pf_stream_prefetcher.md
Name: pf_stream_prefetcher

Overview:
- Parametrised next-N-line stream prefetcher between the L2/L1 cache miss path and the memory arbiter's prefetch port.
- A demand-miss trigger (line address + victim way) launches up to DEPTH sequential line reads, one at a time, bounded by a page boundary.
- Returned lines are buffered in a DEPTH-entry FIFO and handed to the cache over a valid/ack handshake.
- Supersedes the single-line, non-buffered prefetcher.

Parameters:
- DEPTH, 2, max lines fetched ahead per trigger and FIFO entries (1..8).
- WAY_W, 1, width of cache way tag carried with each line.
- PAGE_BITS, 12, prefetch never crosses a 2^PAGE_BITS-byte region of the trigger address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- prefetch_start  in  1  one-cycle trigger from cache on demand miss.
- cacheline_address  in  32  miss address; bits [4:0] ignored.
- cache_way  in  WAY_W  way to be filled with prefetched lines.
- pf_valid  out  1  FIFO head valid.
- prefetch_rdata  out  256  FIFO head data.
- pf_cline_address  out  32  FIFO head line address, bits [4:0]=0.
- pf_cache_way  out  WAY_W  FIFO head way.
- pf_ack  in  1  cache consumes head when pf_valid.
- pf_read  out  1  memory read request.
- pf_address  out  32  memory read line address.
- pf_rdata  in  256  memory read data.
- pf_resp  in  1  memory read complete; pf_rdata valid this cycle.
- pf_busy  out  1  high when state != IDLE or remaining != 0.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on posedge clk.
  - rst (synchronous, active-high) wins over every other input.
  - On rst: state=IDLE, FIFO empty, remaining=0, pf_valid=0, pf_read=0, pf_address=0, pf_cline_address=0, pf_cache_way=0, prefetch_rdata=0, pf_busy=0.
- Trigger load (any state):
  - next_addr = {cacheline_address[31:5],5'b0} + 32.
  - remaining = DEPTH; way latched; FIFO flushed.
  - Trigger beats a same-cycle pf_ack: the pop is ignored.
- Page limit: if next_addr[31:PAGE_BITS] != trigger[31:PAGE_BITS] (including 32-bit wrap), remaining is forced to 0 and no request is issued.
- State IDLE:
  - pf_read=0.
  - Go to REQ when remaining!=0 and FIFO count<DEPTH; at most one read is outstanding.
- State REQ:
  - pf_read=1, pf_address=next_addr, both held stable until pf_resp.
  - On pf_resp (no trigger): push {next_addr, way, pf_rdata}; next_addr+=32; remaining-=1; re-apply page limit; go to IDLE.
  - pf_read drops for at least one cycle between requests.
- Trigger in REQ without pf_resp:
  - Load the new trigger and go to ABORT.
  - pf_read and the old pf_address stay asserted, because the arbiter request cannot be withdrawn.
- Trigger in REQ with pf_resp in the same cycle: discard pf_rdata, load the new trigger, go to IDLE.
- State ABORT:
  - pf_read=1 with the stale address.
  - On pf_resp: discard data and go to IDLE.
  - A further trigger reloads the parameters and stays in ABORT.
- FIFO:
  - Head outputs are registered.
  - Push and pop in the same cycle is allowed, and count is unchanged.
  - A push is never attempted when full (the IDLE gate guarantees this).
  - Head outputs hold their last values when pf_valid=0.
- Latency: trigger cycle T, pf_read high at T+2, first pf_valid one cycle after pf_resp.

Optional Feature:
- Macro PF_STRIDE_EN. With it defined:
  - The block keeps the previous trigger line and the previous stride (signed, in lines, 8 bits saturating).
  - On trigger, new stride = current line - previous line.
  - If new stride equals the previous stride and is nonzero, step = stride*32 (may be negative); otherwise step = +32.
  - Both next_addr init and increment use step, and the page limit still applies.
- Without it: step is always +32 and no history registers exist.

Test Plan:
- Basic stream: DEPTH=2, trigger 0x1000_0040 way 1, resp after 3 cycles each -> reads 0x1000_0060 then 0x1000_0080; pf_valid with way 1; pf_ack pops both in order; pf_busy=0 afterwards.
- Backpressure: DEPTH=2, no pf_ack -> exactly 2 reads then pf_read stays 0; one ack -> no new read, because remaining=0.
- Page boundary: trigger 0x0000_0FE0 -> no pf_read at all; trigger 0x0000_0FC0 -> single read 0x0000_0FE0 only.
- Abort: trigger 0x2000, then trigger 0x8000 while REQ for 0x2020 is pending -> pf_read held at 0x2020 until resp, data discarded, next read 0x8020, FIFO holds only 0x8xxx lines.
- Reset mid-REQ: rst high during pf_read -> next cycle pf_read=0, pf_valid=0, pf_busy=0; a late pf_resp is ignored.
- PF_STRIDE_EN: triggers 0x1000, 0x1080, 0x1100 (stride 4 lines, repeated) -> reads 0x1180, 0x1200.
